// File: rtl/account_txn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// account_txn_ctrl : ATM transaction controller and daily-limit reload sweep
// Revision 1.0
// ============================================================================
module account_txn_ctrl #(
    parameter int FINAL_UP_LIMIT_WIDTH   = 15,
    parameter int AVAILABLE_CREDIT_WIDTH = 25,
    parameter int RAM_DATA_WIDTH         = FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH,
    parameter int RAM_MEM_SIZE           = 64,
    parameter int DAILY_LIMIT            = 20000,
    localparam int AW                    = $clog2(RAM_MEM_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [AW-1:0]                     req_acct,
    input  logic [1:0]                        req_type,
    input  logic [AVAILABLE_CREDIT_WIDTH-1:0] req_amount,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [2:0]                        rsp_status,
    output logic [AVAILABLE_CREDIT_WIDTH-1:0] rsp_credit,
    output logic [FINAL_UP_LIMIT_WIDTH-1:0]   rsp_limit,
    input  logic                              reload_start,
    output logic                              reload_done,
    output logic                              busy,
    output logic                              ram_we,
    output logic [AW-1:0]                     ram_addr,
    output logic [RAM_DATA_WIDTH-1:0]         ram_wdata,
    input  logic [RAM_DATA_WIDTH-1:0]         ram_rdata
);
    localparam int FW = FINAL_UP_LIMIT_WIDTH;
    localparam int CW = AVAILABLE_CREDIT_WIDTH;

    localparam logic [FW-1:0] c_daily_limit = FW'(DAILY_LIMIT);
    localparam logic [AW-1:0] c_last_idx    = AW'(RAM_MEM_SIZE - 1);

    localparam logic [2:0] c_st_ok       = 3'b000;
    localparam logic [2:0] c_st_no_cred  = 3'b001;
    localparam logic [2:0] c_st_limit    = 3'b010;
    localparam logic [2:0] c_st_overflow = 3'b011;
    localparam logic [2:0] c_st_zero     = 3'b100;
    localparam logic [2:0] c_st_illegal  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_RESP   = 3'd3,
        ST_RELOAD = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_acct, r_idx;
    logic [1:0]      r_type;
    logic [CW-1:0]   r_amount, r_credit;
    logic [FW-1:0]   r_limit;

    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_limit_ext, w_new_credit;
    logic [FW-1:0]   w_new_limit;
    logic [2:0]      w_status;
    logic            w_commit;

    // Deposit carry is taken from one bit above the credit field.
    assign w_sum       = {1'b0, r_credit} + {1'b0, r_amount};
    assign w_limit_ext = {{(CW-FW){1'b0}}, r_limit};

    always_comb begin
        w_status     = c_st_ok;
        w_new_credit = r_credit;
        w_new_limit  = r_limit;
        w_commit     = 1'b0;
        if (r_type == 2'b11) begin
            w_status = c_st_illegal;
        end else if (r_type != 2'b00 && r_amount == '0) begin
            w_status = c_st_zero;
        end else if (r_type == 2'b01) begin
            if (r_amount > r_credit) begin
                w_status = c_st_no_cred;
            end else if (r_amount > w_limit_ext) begin
                w_status = c_st_limit;
            end else begin
                w_commit     = 1'b1;
                w_new_credit = r_credit - r_amount;
                w_new_limit  = r_limit - r_amount[FW-1:0];
            end
        end else if (r_type == 2'b10) begin
            if (w_sum[CW]) begin
                w_status = c_st_overflow;
            end else begin
                w_commit     = 1'b1;
                w_new_credit = w_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = ~reload_start;
                if (reload_start)   w_state_next = ST_RELOAD;
                else if (req_valid) w_state_next = ST_READ;
            end
            ST_READ: begin
                busy         = 1'b1;
                ram_addr     = r_acct;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy         = 1'b1;
                ram_addr     = r_acct;
                ram_we       = w_commit;
                ram_wdata    = {w_new_limit, w_new_credit};
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            ST_RELOAD: begin
                busy      = 1'b1;
                ram_addr  = r_idx;
                ram_we    = 1'b1;
                ram_wdata = {c_daily_limit, ram_rdata[CW-1:0]};
                if (r_idx == c_last_idx) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Reset silences every output, including the in-flight RAM write.
        if (rst) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            busy      = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acct      <= '0;
            r_type      <= '0;
            r_amount    <= '0;
            r_credit    <= '0;
            r_limit     <= '0;
            r_idx       <= '0;
            rsp_status  <= '0;
            rsp_credit  <= '0;
            rsp_limit   <= '0;
            reload_done <= 1'b0;
        end else begin
            reload_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (reload_start) begin
                        r_idx <= '0;
                    end else if (req_valid) begin
                        r_acct   <= req_acct;
                        r_type   <= req_type;
                        r_amount <= req_amount;
                    end
                end
                ST_READ: {r_limit, r_credit} <= ram_rdata;
                ST_EXEC: begin
                    rsp_status <= w_status;
                    rsp_credit <= w_new_credit;
                    rsp_limit  <= w_new_limit;
                end
                ST_RELOAD: begin
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == c_last_idx) reload_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_account_txn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_account_txn_ctrl : scoreboard bench with a RAM model and reference model
// Revision 1.0
// ============================================================================
module tb_account_txn_ctrl;
    localparam int FW = 15, CW = 25, DW = 40, N = 64, AW = 6, DAILY = 20000;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_acct = '0;
    logic [1:0] req_type = '0;
    logic [CW-1:0] req_amount = '0;
    logic rsp_valid, rsp_ready = 1'b1;
    logic [2:0] rsp_status;
    logic [CW-1:0] rsp_credit;
    logic [FW-1:0] rsp_limit;
    logic reload_start = 1'b0, reload_done, busy, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    account_txn_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_acct(req_acct), .req_type(req_type), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_credit(rsp_credit), .rsp_limit(rsp_limit), .reload_start(reload_start),
        .reload_done(reload_done), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Account RAM: asynchronous read, synchronous write, plus a bench preload port.
    logic [DW-1:0] ram [N];
    logic pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int wr_count = 0;
    int cyc = 0;
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
            wr_count <= wr_count + 1;
        end
        if (pre_en) ram[pre_addr] <= pre_data;
    end

    // Reference model of account contents.
    longint m_credit [N];
    longint m_limit  [N];

    typedef struct packed {
        logic [2:0]    st;
        logic [CW-1:0] cr;
        logic [FW-1:0] lm;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0;
    int ready_mode = 0;
    int done_cnt = 0, done_cyc = 0, rl_start_cyc = 0;
    logic done_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_status", rsp_status, e.st);
                check("rsp_credit", rsp_credit, e.cr);
                check("rsp_limit",  rsp_limit,  e.lm);
            end
        end
    end

    always @(negedge clk) begin
        if (reload_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic model_txn(input int a, input int t, input longint amt, output exp_t e);
        longint cr, lm;
        int st;
        cr = m_credit[a];
        lm = m_limit[a];
        st = 0;
        if (t == 3)                      st = 5;
        else if (t != 0 && amt == 0)     st = 4;
        else if (t == 1) begin
            if (amt > cr)                st = 1;
            else if (amt > lm)           st = 2;
            else begin cr -= amt; lm -= amt; end
        end else if (t == 2) begin
            if (cr + amt >= (64'd1 << 25)) st = 3;
            else cr += amt;
        end
        m_credit[a] = cr;
        m_limit[a]  = lm;
        e.st = 3'(st);
        e.cr = CW'(cr);
        e.lm = FW'(lm);
    endtask

    // All tasks below start and end just after a rising edge.
    task automatic set_acct(input int a, input longint lm, input longint cr);
        pre_en   = 1'b1;
        pre_addr = AW'(a);
        pre_data = {FW'(lm), CW'(cr)};
        @(posedge clk); #1;
        pre_en   = 1'b0;
        m_limit[a]  = lm;
        m_credit[a] = cr;
    endtask

    task automatic issue(input int a, input int t, input longint amt, input bit with_reload);
        exp_t e;
        bit got;
        req_valid  = 1'b1;
        req_acct   = AW'(a);
        req_type   = 2'(t);
        req_amount = CW'(amt);
        if (with_reload) begin
            reload_start = 1'b1;
            @(negedge clk);
            check("req_ready_during_reload_start", req_ready, 0);
            rl_start_cyc = cyc;
            @(posedge clk); #1;
            reload_start = 1'b0;
            for (int i = 0; i < N; i++) m_limit[i] = DAILY;
        end
        model_txn(a, t, amt, e);
        q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        check("req_accept", got, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, a, t, r;
        longint amt, cr, lm;
        bit seen;

        // Preload every account while the controller is held in reset.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            set_acct(i, $urandom_range(0, DAILY), $urandom_range(0, (1 << 25) - 1));
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_reload_done", reload_done, 0);
        check("rst_rsp_fields", {rsp_status, rsp_credit, rsp_limit}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // OK withdraw with cycle-accurate latency.
        set_acct(5, 1000, 5000);
        issue(5, 1, 300, 0);
        @(negedge clk);
        check("lat_read_we", ram_we, 0);
        check("lat_read_valid", rsp_valid, 0);
        @(negedge clk);
        check("lat_exec_we", ram_we, 1);
        check("lat_exec_addr", ram_addr, 5);
        check("lat_exec_wdata", ram_wdata, {15'd700, 25'd4700});
        @(negedge clk);
        check("lat_resp_valid", rsp_valid, 1);
        check("lat_ram5", ram[5], {15'd700, 25'd4700});
        @(posedge clk); #1;
        drain();

        // Failing withdraws never write.
        wc = wr_count;
        set_acct(5, 1000, 200);
        issue(5, 1, 300, 0);
        set_acct(5, 100, 5000);
        drain();
        issue(5, 1, 300, 0);
        drain();
        check("fail_no_write", wr_count, wc);

        // Deposit carry boundary.
        set_acct(0, 1234, (1 << 25) - 10);
        wc = wr_count;
        issue(0, 2, 10, 0);
        drain();
        check("overflow_no_write", wr_count, wc);
        issue(0, 2, 9, 0);
        drain();
        check("deposit_write", wr_count, wc + 1);

        // Reload requested together with a request.
        done_cnt = 0;
        issue(9, 1, 500, 1);
        drain();
        check("reload_done_count", done_cnt, 1);
        check("reload_done_cycle", done_cyc - rl_start_cyc, N + 1);
        check("reload_done_busy", done_busy, 0);
        for (int i = 0; i < N; i++)
            if (i != 9) check($sformatf("reload_mem[%0d]", i), ram[i], {FW'(m_limit[i]), CW'(m_credit[i])});

        // Response stall then back-to-back same-account withdraws.
        set_acct(3, 1000, 1000);
        ready_mode = 1;
        issue(3, 1, 100, 0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("stall_rsp_valid_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_rsp_hold", {rsp_valid, rsp_status, rsp_credit, rsp_limit},
                  {1'b1, 3'd0, 25'd900, 15'd900});
            check("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        ready_mode = 0;
        issue(3, 1, 100, 0);
        drain();
        check("b2b_ram3", ram[3], {15'd800, 25'd800});

        // Reset during EXEC of an OK withdraw.
        set_acct(7, 1000, 5000);
        wc = wr_count;
        req_valid = 1'b1; req_acct = 7; req_type = 2'b01; req_amount = 300;
        @(negedge clk);
        check("rst_exec_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_exec_we", ram_we, 0);
        check("rst_exec_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_exec_idle_ready", req_ready, 1);
        check("rst_exec_no_rsp", rsp_valid, 0);
        check("rst_exec_no_write", wr_count, wc);
        @(posedge clk); #1;

        // Illegal type, zero amounts, inquiry.
        issue(4, 3, 50, 0);
        issue(4, 1, 0, 0);
        issue(4, 2, 0, 0);
        issue(4, 0, 0, 0);
        drain();

        // Randomized traffic with random response back-pressure.
        ready_mode = 2;
        for (int n = 0; n < 200; n++) begin
            a  = $urandom_range(0, N - 1);
            r  = $urandom_range(0, 9);
            t  = (r == 0) ? 3 : (r < 3) ? 0 : (r < 7) ? 1 : 2;
            cr = m_credit[a];
            lm = m_limit[a];
            case ($urandom_range(0, 5))
                0:       amt = 0;
                1:       amt = lm + $urandom_range(0, 1);
                2:       amt = cr + $urandom_range(0, 1);
                3:       amt = (64'd1 << 25) - cr - $urandom_range(0, 1);
                4:       amt = $urandom_range(1, 1000);
                default: amt = $urandom;
            endcase
            amt = amt & ((64'd1 << 25) - 1);
            issue(a, t, amt, 0);
        end
        drain();
        ready_mode = 0;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++)
            check($sformatf("final_mem[%0d]", i), ram[i], {FW'(m_limit[i]), CW'(m_credit[i])});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/account_txn_ctrl.md
# account_txn_ctrl

Transaction controller sitting directly upstream of the account `single_port_ram`. It accepts one ATM transaction at a time (balance inquiry, withdrawal, deposit) over a valid/ready handshake and reads the addressed account word. It checks the request against the account's available credit and remaining withdrawal limit, writes the updated word back, and returns a status and resulting balances. It also runs a limit-reload sweep that restores every account's withdrawal limit to `DAILY_LIMIT`.

## Interface
- `FINAL_UP_LIMIT_WIDTH`, 15, width of the remaining-withdrawal-limit field
- `AVAILABLE_CREDIT_WIDTH`, 25, width of the credit field and of `req_amount`
- `RAM_DATA_WIDTH`, `FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH`, RAM word width; word is {limit[39:25], credit[24:0]}
- `RAM_MEM_SIZE`, 64, number of accounts; `AW = $clog2(RAM_MEM_SIZE)`
- `DAILY_LIMIT`, 20000, limit value written by the reload sweep

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — controller can accept a request
- `req_acct` in AW — account index
- `req_type` in 2 — 00 inquiry, 01 withdraw, 10 deposit, 11 illegal
- `req_amount` in AVAILABLE_CREDIT_WIDTH — transaction amount
- `rsp_valid` out 1 — response present
- `rsp_ready` in 1 — response consumed
- `rsp_status` out 3 — 000 OK, 001 insufficient credit, 010 limit exceeded, 011 credit overflow, 100 zero amount, 101 illegal type
- `rsp_credit` out AVAILABLE_CREDIT_WIDTH — credit after the transaction
- `rsp_limit` out FINAL_UP_LIMIT_WIDTH — limit after the transaction
- `reload_start` in 1 — request a limit-reload sweep
- `reload_done` out 1 — one-cycle pulse after the sweep completes
- `busy` out 1 — high in any state other than IDLE
- `ram_we` out 1, `ram_addr` out AW, `ram_wdata` out RAM_DATA_WIDTH — RAM write port
- `ram_rdata` in RAM_DATA_WIDTH — RAM asynchronous read data

## Operation
- States: IDLE, READ, EXEC, RESP, RELOAD.
- **IDLE**
  - `req_ready` = 1 unless `reload_start` = 1.
  - `reload_start` has priority: go to RELOAD with sweep index 0, and no request is accepted that cycle.
  - Otherwise `req_valid && req_ready` latches acct/type/amount and goes to READ.
- **READ**
  - `ram_addr` = latched acct.
  - Capture `ram_rdata` into the limit/credit registers.
  - Go to EXEC.
- **EXEC** — evaluate, first failure wins:
  - type 11 → 101.
  - Type 01/10 with amount 0 → 100.
  - Withdraw, amount > credit → 001.
  - Withdraw, amount > zero-extended limit → 010.
  - Deposit, credit + amount ≥ 2^25 (carry out) → 011.
  - Otherwise → 000.
- **EXEC writes**
  - On OK withdraw: credit −= amount, limit −= amount.
  - On OK deposit: credit += amount; limit is unchanged.
  - `ram_we` = 1 only for an OK withdraw or deposit, with `ram_addr` = acct and `ram_wdata` = {new limit, new credit}.
  - Inquiry and failures never write.
  - `rsp_*` registers load the post-transaction values (unchanged values on failure).
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1, outputs stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- **RELOAD**
  - One entry per cycle: `ram_addr` = idx, `ram_we` = 1, `ram_wdata` = {DAILY_LIMIT, ram_rdata[24:0]}.
  - idx increments each cycle.
  - After the write at idx = RAM_MEM_SIZE−1, go to IDLE and pulse `reload_done` on the next cycle.
- `ram_we` is forced to 0 whenever `rst` = 1.
- `reload_start` outside IDLE is ignored, not queued.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_ready` 0 while `rst` is high, 1 on the first cycle after.
  - `rsp_valid`, `rsp_status`, `rsp_credit`, `rsp_limit`, `reload_done`, `busy`, `ram_we`, `ram_addr`, `ram_wdata` all 0.
- **Request latency:**
  - Accept at cycle N.
  - READ at N+1.
  - EXEC/RAM write at N+2; memory is updated at the end of N+2.
  - `rsp_valid` at N+3.
  - Earliest next accept is the cycle after the response handshake. A same-account back-to-back request therefore reads the updated word.
- **Throughput:** one transaction per 4 cycles when `rsp_ready` is held high.
- **Reload:**
  - `reload_start` at cycle N.
  - Writes at N+1 … N+RAM_MEM_SIZE.
  - `reload_done` at N+RAM_MEM_SIZE+1; `busy` is low in that cycle.
- **Reset mid-operation:**
  - Returns to IDLE and drops `rsp_valid`.
  - No write in the reset cycle.
  - A partially completed sweep leaves already-written entries reloaded; no `reload_done`.
- **Arithmetic:** subtraction can never underflow because of the prior checks. The deposit carry is detected on a 26-bit sum.

## Test plan
- Acct 5 = {limit 1000, credit 5000}, withdraw 300 → status 000, credit 4700, limit 700; RAM[5] updated at cycle N+2, `rsp_valid` at N+3.
- Acct 5 = {1000, 200}, withdraw 300 → 001. Acct 5 = {100, 5000}, withdraw 300 → 010. Neither case asserts `ram_we`.
- Acct 0 credit 2^25−10, deposit 10 → 011, no write. Deposit 9 → 000, credit 2^25−1, limit unchanged.
- `reload_start` together with `req_valid` in IDLE → request stalled (`req_ready` = 0). All 64 limits become 20000 with credits intact. `reload_done` pulses once at N+65, after which the request is accepted.
- `rsp_ready` held low 5 cycles → `rsp_*` stable and `req_ready` = 0. Then two back-to-back withdraws of 100 on acct 3 {1000, 1000} → second response is credit 800, limit 800.
- `rst` asserted during EXEC of an OK withdraw → no RAM write and `rsp_valid` 0. Type 11 and zero-amount requests → 101 and 100.
